// File: rtl/ball_motion_renderer.sv
// Square ball for an 800x600 raster: frame-rate motion, wall bounces, bottom miss
// with serve delay, and a registered per-pixel mask/colour output.
module ball_motion_renderer #(
   parameter int          H_RES        = 800,
   parameter int          V_RES        = 600,
   parameter int          SIZE         = 16,
   parameter int          SPEED        = 4,
   parameter int          START_X      = 392,
   parameter int          START_Y      = 292,
   parameter int          SERVE_FRAMES = 60,
   parameter logic [11:0] COLOR        = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        launch,
   output logic        pixel_on,
   output logic [11:0] rgb,
   output logic [9:0]  ball_x,
   output logic [9:0]  ball_y,
   output logic        bounce,
   output logic        miss,
   output logic [1:0]  state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_MOVING = 2'd1;
   localparam logic [1:0] S_SERVE  = 2'd2;
   localparam int         CW       = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   logic          frame_tick, hit;
   logic          dir_x, dir_y;          // 1 = right / down
   logic [CW-1:0] cnt;
   logic [10:0]   x11, y11, bx11, by11;
   logic [9:0]    nx, ny;
   logic          ndx, ndy, xb, yb, ym;

   assign frame_tick = (x == 10'(H_RES - 1)) && (y == 10'(V_RES - 1));

   // 11-bit compares so ball edge + SIZE never wraps
   assign x11  = {1'b0, x};
   assign y11  = {1'b0, y};
   assign bx11 = {1'b0, ball_x};
   assign by11 = {1'b0, ball_y};
   assign hit  = (x11 >= bx11) && (x11 < bx11 + 11'(SIZE)) &&
                 (y11 >= by11) && (y11 < by11 + 11'(SIZE));

   always_comb begin
      nx  = ball_x;
      ny  = ball_y;
      ndx = dir_x;
      ndy = dir_y;
      xb  = 1'b0;
      yb  = 1'b0;
      ym  = 1'b0;
      if (!dir_x) begin
         if (bx11 < 11'(SPEED)) begin
            nx = 10'd0; ndx = 1'b1; xb = 1'b1;
         end else begin
            nx = ball_x - 10'(SPEED);
         end
      end else begin
         if (bx11 + 11'(SPEED + SIZE) > 11'(H_RES)) begin
            nx = 10'(H_RES - SIZE); ndx = 1'b0; xb = 1'b1;
         end else begin
            nx = ball_x + 10'(SPEED);
         end
      end
      if (!dir_y) begin
         if (by11 < 11'(SPEED)) begin
            ny = 10'd0; ndy = 1'b1; yb = 1'b1;
         end else begin
            ny = ball_y - 10'(SPEED);
         end
      end else begin
         if (by11 + 11'(SPEED + SIZE) > 11'(V_RES)) ym = 1'b1;
         else                                       ny = ball_y + 10'(SPEED);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ball_x   <= 10'(START_X);
         ball_y   <= 10'(START_Y);
         dir_x    <= 1'b0;
         dir_y    <= 1'b0;
         cnt      <= '0;
         pixel_on <= 1'b0;
         rgb      <= 12'h000;
         bounce   <= 1'b0;
         miss     <= 1'b0;
      end else begin
         pixel_on <= hit;
         rgb      <= hit ? COLOR : 12'h000;
         bounce   <= 1'b0;
         miss     <= 1'b0;
         case (state)
            S_IDLE: if (launch) begin
               state <= S_MOVING;
               dir_x <= 1'b0;
               dir_y <= 1'b0;
            end
            S_MOVING: if (frame_tick) begin
               if (ym) begin
                  // miss wins over any simultaneous X bounce
                  miss   <= 1'b1;
                  ball_x <= 10'(START_X);
                  ball_y <= 10'(START_Y);
                  dir_x  <= 1'b0;
                  dir_y  <= 1'b0;
                  state  <= S_SERVE;
                  cnt    <= '0;
               end else begin
                  ball_x <= nx;
                  ball_y <= ny;
                  dir_x  <= ndx;
                  dir_y  <= ndy;
                  bounce <= xb | yb;
               end
            end
            S_SERVE: if (frame_tick) begin
               if (cnt == CW'(SERVE_FRAMES - 1)) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
